// File: rtl/ram_fb_pkg.sv
// rtl/ram_fb_pkg.sv - shared types and default constants for the framebuffer RAM
//
// Holds the scan-engine state encoding and the default framebuffer geometry
// used by ram_fb_scan and fb_scan_ctrl. No ports.
package ram_fb_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        SCAN  = 2'd2
    } scan_state_t;

    localparam int FB_BASE_DEF      = 'hC0;
    localparam int FB_LEN_DEF       = 64;
    localparam int LINE_LEN_DEF     = 16;
    localparam int FILL_CHAR_DEF    = 'h2D;
    localparam int FRAME_PERIOD_DEF = 100;

endpackage

// File: rtl/fb_scan_ctrl.sv
// rtl/fb_scan_ctrl.sv - framebuffer scan-out FSM, period timer, pointer and output register
//
// Walks the framebuffer window and presents one byte at a time on a
// valid/ready stream, tagging first-of-frame, end-of-line and end-of-frame.
// With FB_CLEAR_EN defined the same pointer first sweeps the window after
// reset so the top level can write FILL_CHAR into every word.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   frame_req       request a frame start
//   scan_ready      sink accepts the presented byte
//   fetch_data      asynchronous array read of mem[ptr]
//   ptr             current framebuffer address (fetch or clear target)
//   busy            clear in progress; CPU port must drop accesses
//   clr_we          write FILL_CHAR to mem[ptr] this cycle
//   scan_data/valid output byte register and its valid
//   scan_sof/eol/eof byte qualifiers
//   frame_overrun   1-cycle pulse when a frame start was dropped
module fb_scan_ctrl
    import ram_fb_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] FB_BASE      = ADDR_W'(FB_BASE_DEF),
    parameter int                FB_LEN       = FB_LEN_DEF,
    parameter int                LINE_LEN     = LINE_LEN_DEF,
    parameter int                FRAME_PERIOD = FRAME_PERIOD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_req,
    input  logic              scan_ready,
    input  logic [DATA_W-1:0] fetch_data,
    output logic [ADDR_W-1:0] ptr,
    output logic              busy,
    output logic              clr_we,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    output logic              scan_sof,
    output logic              scan_eol,
    output logic              scan_eof,
    output logic              frame_overrun
);

    localparam int IDX_W = $clog2(FB_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FB_LEN - 1);
    localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(FB_LEN);
    localparam int PER_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'((FRAME_PERIOD > 0) ? FRAME_PERIOD - 1 : 0);

`ifdef FB_CLEAR_EN
    localparam scan_state_t RESET_STATE = CLEAR;
`else
    localparam scan_state_t RESET_STATE = IDLE;
`endif

    scan_state_t      state;
    scan_state_t      state_nxt;
    logic [IDX_W-1:0] idx;          // words fetched (SCAN) or cleared (CLEAR)
    logic             period_hit;
    logic             frame_start;
    logic             fetch_en;
    logic             eof_accept;
    logic             clr_last;
    logic             fetched_all;

    assign ptr         = FB_BASE + ADDR_W'(idx);
    assign frame_start = frame_req || period_hit;
    assign clr_last    = (idx == LAST_IDX);
    assign fetched_all = (idx == END_IDX);

    generate
        if (FRAME_PERIOD > 0) begin : g_period
            logic [PER_W-1:0] per_cnt;

            // Free-running: automatic starts keep a fixed cadence even when
            // some of them are dropped as overruns.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    per_cnt <= '0;
                end else if (per_cnt == PER_LAST) begin
                    per_cnt <= '0;
                end else begin
                    per_cnt <= per_cnt + 1'b1;
                end
            end

            assign period_hit = (per_cnt == PER_LAST);
        end else begin : g_no_period
            assign period_hit = 1'b0;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_last)    state_nxt = IDLE;
            IDLE:    if (frame_start) state_nxt = SCAN;
            SCAN:    if (eof_accept)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
`ifdef FB_CLEAR_EN
        busy   = (state == CLEAR);
        clr_we = (state == CLEAR);
`else
        busy   = 1'b0;
        clr_we = 1'b0;
`endif
        // The eof byte is the last fetch, so fetch_en and eof_accept never
        // coincide; the output register refills as soon as it drains.
        fetch_en   = (state == SCAN) && (!scan_valid || scan_ready) && !fetched_all;
        eof_accept = (state == SCAN) && scan_valid && scan_ready && scan_eof;
    end

    // Pointer, output register and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            scan_data     <= '0;
            scan_valid    <= 1'b0;
            scan_sof      <= 1'b0;
            scan_eol      <= 1'b0;
            scan_eof      <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            frame_overrun <= frame_start && (state != IDLE);
            case (state)
                CLEAR: begin
                    idx <= clr_last ? '0 : idx + 1'b1;
                end
                IDLE: begin
                    idx <= '0;
                end
                SCAN: begin
                    if (eof_accept) begin
                        scan_valid <= 1'b0;
                        scan_sof   <= 1'b0;
                        scan_eol   <= 1'b0;
                        scan_eof   <= 1'b0;
                    end else if (fetch_en) begin
                        scan_data  <= fetch_data;
                        scan_valid <= 1'b1;
                        scan_sof   <= (idx == '0);
                        scan_eol   <= ((32'(idx) % LINE_LEN) == LINE_LEN - 1);
                        scan_eof   <= (idx == LAST_IDX);
                        idx        <= idx + 1'b1;
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_fb_scan.sv
// rtl/ram_fb_scan.sv - CPU data RAM with framebuffer scan-out stream
//
// Single array with a CPU port (synchronous write, registered read) and a
// read-only scan port driven by fb_scan_ctrl. Optional FB_CLEAR_EN fills the
// framebuffer window with FILL_CHAR after reset while busy is high.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   MemWrite, MemRead   CPU write / read strobes (dropped while busy)
//   addr, wdata         CPU address and write data
//   out, rd_valid       registered read data and its 1-cycle update pulse
//   busy                framebuffer clear in progress
//   frame_req           start a scan frame
//   scan_data/valid/ready, scan_sof/eol/eof  framebuffer byte stream
//   frame_overrun       frame start dropped because the engine was active
module ram_fb_scan
    import ram_fb_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] FB_BASE      = ADDR_W'(FB_BASE_DEF),
    parameter int                FB_LEN       = FB_LEN_DEF,
    parameter int                LINE_LEN     = LINE_LEN_DEF,
    parameter int                FRAME_PERIOD = FRAME_PERIOD_DEF,
    parameter logic [DATA_W-1:0] FILL_CHAR    = DATA_W'(FILL_CHAR_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] out,
    output logic              rd_valid,
    output logic              busy,
    input  logic              frame_req,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    input  logic              scan_ready,
    output logic              scan_sof,
    output logic              scan_eol,
    output logic              scan_eof,
    output logic              frame_overrun
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] ptr;
    logic              clr_we;

    fb_scan_ctrl #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .FB_BASE      (FB_BASE),
        .FB_LEN       (FB_LEN),
        .LINE_LEN     (LINE_LEN),
        .FRAME_PERIOD (FRAME_PERIOD)
    ) u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_req     (frame_req),
        .scan_ready    (scan_ready),
        .fetch_data    (mem[ptr]),
        .ptr           (ptr),
        .busy          (busy),
        .clr_we        (clr_we),
        .scan_data     (scan_data),
        .scan_valid    (scan_valid),
        .scan_sof      (scan_sof),
        .scan_eol      (scan_eol),
        .scan_eof      (scan_eof),
        .frame_overrun (frame_overrun)
    );

    // Array contents are deliberately not reset. The scan fetch reads the
    // array combinationally, so a CPU write landing on the same edge as a
    // fetch of that word is seen by the next frame, not this one.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ptr] <= FILL_CHAR;
        end else if (MemWrite && !busy) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read: same-edge write to the same address returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out      <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= MemRead && !busy;
            if (MemRead && !busy) begin
                out <= mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_ram_fb_scan.sv
// tb/tb_ram_fb_scan.sv - directed self-checking bench for ram_fb_scan
module tb_ram_fb_scan;

    logic       clk;
    logic       rst_n;
    logic       MemWrite;
    logic       MemRead;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] out;
    logic       rd_valid;
    logic       busy;
    logic       frame_req;
    logic [7:0] scan_data;
    logic       scan_valid;
    logic       scan_ready;
    logic       scan_sof;
    logic       scan_eol;
    logic       scan_eof;
    logic       frame_overrun;

    logic [7:0] p_out;
    logic       p_rd_valid;
    logic       p_busy;
    logic [7:0] p_data;
    logic       p_valid;
    logic       p_sof;
    logic       p_eol;
    logic       p_eof;
    logic       p_overrun;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_fb [64];

    ram_fb_scan #(.FRAME_PERIOD(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .MemWrite      (MemWrite),
        .MemRead       (MemRead),
        .addr          (addr),
        .wdata         (wdata),
        .out           (out),
        .rd_valid      (rd_valid),
        .busy          (busy),
        .frame_req     (frame_req),
        .scan_data     (scan_data),
        .scan_valid    (scan_valid),
        .scan_ready    (scan_ready),
        .scan_sof      (scan_sof),
        .scan_eol      (scan_eol),
        .scan_eof      (scan_eof),
        .frame_overrun (frame_overrun)
    );

    ram_fb_scan #(.FRAME_PERIOD(100)) dut_p (
        .clk           (clk),
        .rst_n         (rst_n),
        .MemWrite      (1'b0),
        .MemRead       (1'b0),
        .addr          (8'h00),
        .wdata         (8'h00),
        .out           (p_out),
        .rd_valid      (p_rd_valid),
        .busy          (p_busy),
        .frame_req     (1'b0),
        .scan_data     (p_data),
        .scan_valid    (p_valid),
        .scan_ready    (1'b1),
        .scan_sof      (p_sof),
        .scan_eol      (p_eol),
        .scan_eof      (p_eof),
        .frame_overrun (p_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Starts a frame and consumes it. toggle: ready alternates 0/1 per
    // presented cycle. ovr: extra frame_req mid-frame. poke: CPU write of
    // 0x7A to 0xF0 right after the first byte appears.
    task automatic run_frame(input string tag, input bit toggle, input bit ovr, input bit poke);
        int         n_acc    = 0;
        int         n_vis    = 0;
        int         cyc      = 0;
        bit         stalled  = 0;
        bit         ovr_pend = 0;
        bit         ovr_done = 0;
        logic [7:0] hold_data  = 8'h00;
        logic [2:0] hold_flags = 3'b000;
        @(negedge clk);
        frame_req  = 1'b1;
        scan_ready = !toggle;
        @(negedge clk);
        frame_req = 1'b0;
        chk({tag, "_lat0_valid"}, 32'(scan_valid), 0);
        @(negedge clk);
        chk({tag, "_lat1_valid"}, 32'(scan_valid), 1);
        while (n_acc < 64 && cyc < 400) begin
            if (poke) begin
                if (n_vis == 0) begin
                    MemWrite  = 1'b1;
                    addr      = 8'hF0;
                    wdata     = 8'h7A;
                    exp_fb[48] = 8'h7A;
                end else begin
                    MemWrite = 1'b0;
                end
            end
            if (ovr_pend) begin
                chk({tag, "_overrun"}, 32'(frame_overrun), 1);
                frame_req = 1'b0;
                ovr_pend  = 1'b0;
            end else if (ovr && !ovr_done && n_vis == 10) begin
                frame_req = 1'b1;
                ovr_pend  = 1'b1;
                ovr_done  = 1'b1;
            end
            if (scan_valid) begin
                if (toggle) scan_ready = n_vis[0];
                if (stalled) begin
                    chk({tag, "_hold_data"}, 32'(scan_data), 32'(hold_data));
                    chk({tag, "_hold_flags"}, 32'({scan_sof, scan_eol, scan_eof}), 32'(hold_flags));
                end
                if (scan_ready) begin
                    chk({tag, "_data"}, 32'(scan_data), 32'(exp_fb[n_acc]));
                    chk({tag, "_flags"}, 32'({scan_sof, scan_eol, scan_eof}),
                        32'({n_acc == 0, (n_acc % 16) == 15, n_acc == 63}));
                    n_acc++;
                end
                stalled    = !scan_ready;
                hold_data  = scan_data;
                hold_flags = {scan_sof, scan_eol, scan_eof};
                n_vis++;
            end
            @(negedge clk);
            cyc++;
        end
        MemWrite  = 1'b0;
        frame_req = 1'b0;
        chk({tag, "_bytes"}, 32'(n_acc), 64);
        chk({tag, "_end_valid"}, 32'(scan_valid), 0);
        chk({tag, "_cycles"}, 32'(n_vis), toggle ? 128 : 64);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        addr       = 8'h00;
        wdata      = 8'h00;
        frame_req  = 1'b0;
        scan_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(out), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_scan_valid", 32'(scan_valid), 0);
        chk("rst_flags", 32'({scan_sof, scan_eol, scan_eof}), 0);
        chk("rst_overrun", 32'(frame_overrun), 0);
        rst_n = 1'b1;

`ifdef FB_CLEAR_EN
        count_busy(n);
        chk("clear_busy_len", 32'(n), 64);
        for (int i = 0; i < 64; i++) exp_fb[i] = 8'h2D;
        run_frame("clr_frame", 1'b0, 1'b0, 1'b0);
`else
        @(negedge clk);
        chk("busy_tied", 32'(busy), 0);
`endif

        // CPU port: write, registered read, read-during-write
        MemWrite = 1'b1; addr = 8'h10; wdata = 8'h41;
        @(negedge clk);
        MemWrite = 1'b0; MemRead = 1'b1;
        @(negedge clk);
        chk("rd_data", 32'(out), 'h41);
        chk("rd_valid_pulse", 32'(rd_valid), 1);
        MemRead = 1'b0;
        @(negedge clk);
        chk("rd_valid_clear", 32'(rd_valid), 0);
        chk("rd_hold", 32'(out), 'h41);
        MemWrite = 1'b1; MemRead = 1'b1; wdata = 8'h55;
        @(negedge clk);
        chk("rdw_old", 32'(out), 'h41);
        MemWrite = 1'b0;
        @(negedge clk);
        chk("rdw_new", 32'(out), 'h55);
        MemRead = 1'b0;

        // Fill framebuffer with 0x00..0x3F
        for (int i = 0; i < 64; i++) begin
            MemWrite = 1'b1;
            addr     = 8'hC0 + 8'(i);
            wdata    = 8'(i);
            exp_fb[i] = 8'(i);
            @(negedge clk);
        end
        MemWrite = 1'b0;

        run_frame("frame_ready", 1'b0, 1'b0, 1'b0);
        run_frame("frame_toggle", 1'b1, 1'b0, 1'b0);
        run_frame("frame_ovr", 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("ovr_no_restart", 32'(scan_valid), 0);
        run_frame("frame_poke", 1'b0, 1'b0, 1'b1);

        // Automatic frames on the FRAME_PERIOD=100 instance
        n = 0;
        while (!(p_valid && p_sof) && n < 300) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p_valid && p_sof) && n < 300);
        chk("period_spacing", 32'(n), 100);

`ifdef FB_CLEAR_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        chk("clear_restart_len", 32'(n), 64);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
